// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave cook-cycle sequencer.
package microwave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } cook_state_t;

  typedef logic [3:0] bcd_t;

  localparam logic [11:0] QUICK_TIME = 12'h030;

endpackage

// File: rtl/tick_prescaler.sv
// Mod-TICK_DIV counter: counts while en, holds otherwise, clr forces zero.
// tick is high for the one cycle the counter sits on its terminal count while enabled.
module tick_prescaler #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic clrn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en & ~clr & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/microwave_cook_ctrl.sv
// Cook-cycle sequencer: keypad entry, counter-chain load, 1 s count enables, door/pause/beep.
// Define QUICK_START_EN to make a start with an empty entry load 30 s and cook.
module microwave_cook_ctrl
  import microwave_pkg::*;
#(
  parameter int TICK_DIV   = 100,
  parameter int BEEP_TICKS = 3
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start,
  input  logic        stop_clr,
  input  logic        door_closed,
  input  logic        timer_zero,
  output logic [11:0] load_data,
  output logic        timer_loadn,
  output logic        timer_en,
  output logic        mag_on,
  output logic        lamp_on,
  output logic        beep,
  output logic [2:0]  state
);

`ifdef QUICK_START_EN
  localparam bit QUICK_EN = 1'b1;
`else
  localparam bit QUICK_EN = 1'b0;
`endif

  localparam logic [7:0] BEEP_LAST = 8'(BEEP_TICKS - 1);

  cook_state_t state_q, state_d;
  logic [11:0] entry_q, entry_d;
  logic [11:0] load_data_q, load_data_d;
  logic        timer_loadn_q, timer_loadn_d;
  logic        timer_en_q, timer_en_d;
  logic        beep_q, beep_d;
  logic        settle_q, settle_d;
  logic [7:0]  beep_cnt_q, beep_cnt_d;

  logic in_cook, in_pause, in_done, cook_to_done, ps_en, ps_clr, ps_tick;

  assign in_cook  = (state_q == ST_COOK);
  assign in_pause = (state_q == ST_PAUSE);
  assign in_done  = (state_q == ST_DONE);

  // settle_q masks timer_zero for the first cycle after a load while the chain updates
  assign cook_to_done = in_cook & door_closed & ~stop_clr & timer_zero & ~settle_q;
  assign ps_en  = (in_cook & door_closed & ~stop_clr & ~cook_to_done)
                | (in_done & door_closed & ~stop_clr);
  assign ps_clr = ~(in_cook | in_pause | in_done) | cook_to_done;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .clrn (clrn),
    .en   (ps_en),
    .clr  (ps_clr),
    .tick (ps_tick)
  );

  always_comb begin
    state_d       = state_q;
    entry_d       = entry_q;
    load_data_d   = load_data_q;
    timer_loadn_d = 1'b1;
    timer_en_d    = 1'b0;
    beep_d        = beep_q;
    beep_cnt_d    = beep_cnt_q;
    settle_d      = 1'b0;
    case (state_q)
      ST_IDLE, ST_ENTRY: begin
        beep_d = 1'b0;
        if (stop_clr) begin
          entry_d = '0;
          state_d = ST_IDLE;
        end else if (start) begin
          if (door_closed && entry_q != 12'h000) begin
            load_data_d   = entry_q;
            timer_loadn_d = 1'b0;
            settle_d      = 1'b1;
            state_d       = ST_COOK;
          end else if (door_closed && QUICK_EN) begin
            entry_d       = QUICK_TIME;
            load_data_d   = QUICK_TIME;
            timer_loadn_d = 1'b0;
            settle_d      = 1'b1;
            state_d       = ST_COOK;
          end
        end else if (key_valid && key_digit <= 4'd9) begin
          entry_d = {entry_q[7:0], bcd_t'(key_digit)};
          state_d = ST_ENTRY;
        end
      end
      ST_COOK: begin
        if (stop_clr || !door_closed) begin
          state_d = ST_PAUSE;
        end else if (cook_to_done) begin
          state_d    = ST_DONE;
          beep_d     = 1'b1;
          beep_cnt_d = '0;
        end else begin
          timer_en_d = ps_tick;
        end
      end
      ST_PAUSE: begin
        if (stop_clr) begin
          entry_d       = '0;
          load_data_d   = '0;
          timer_loadn_d = 1'b0;
          state_d       = ST_IDLE;
        end else if (start && door_closed) begin
          state_d = ST_COOK;
        end
      end
      ST_DONE: begin
        beep_d = 1'b1;
        if (stop_clr || !door_closed) begin
          beep_d     = 1'b0;
          beep_cnt_d = '0;
          state_d    = ST_IDLE;
        end else if (ps_tick) begin
          if (beep_cnt_q == BEEP_LAST) begin
            beep_d     = 1'b0;
            beep_cnt_d = '0;
            state_d    = ST_IDLE;
          end else begin
            beep_cnt_d = beep_cnt_q + 8'd1;
          end
        end
      end
      default: begin
        beep_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q       <= ST_IDLE;
      entry_q       <= '0;
      load_data_q   <= '0;
      timer_loadn_q <= 1'b1;
      timer_en_q    <= 1'b0;
      beep_q        <= 1'b0;
      beep_cnt_q    <= '0;
      settle_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      entry_q       <= entry_d;
      load_data_q   <= load_data_d;
      timer_loadn_q <= timer_loadn_d;
      timer_en_q    <= timer_en_d;
      beep_q        <= beep_d;
      beep_cnt_q    <= beep_cnt_d;
      settle_q      <= settle_d;
    end
  end

  assign load_data   = load_data_q;
  assign timer_loadn = timer_loadn_q;
  assign timer_en    = timer_en_q;
  assign beep        = beep_q;
  assign state       = state_q;
  assign mag_on      = in_cook & door_closed;
  assign lamp_on     = in_cook | ~door_closed;

endmodule

// File: tb/tb_microwave_cook_ctrl.sv
// Directed bench for microwave_cook_ctrl with TICK_DIV=5, BEEP_TICKS=3.
module tb_microwave_cook_ctrl;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = 4'd0;
  logic        start = 1'b0;
  logic        stop_clr = 1'b0;
  logic        door_closed = 1'b1;
  logic        timer_zero = 1'b0;
  logic [11:0] load_data;
  logic        timer_loadn, timer_en, mag_on, lamp_on, beep;
  logic [2:0]  state;

  int n_cmp = 0;
  int n_bad = 0;

  microwave_cook_ctrl #(.TICK_DIV(5), .BEEP_TICKS(3)) dut (
    .clk(clk), .clrn(clrn), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop_clr(stop_clr), .door_closed(door_closed),
    .timer_zero(timer_zero), .load_data(load_data), .timer_loadn(timer_loadn),
    .timer_en(timer_en), .mag_on(mag_on), .lamp_on(lamp_on), .beep(beep),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // Driver tasks: assert at negedge, release 1 ns after the sampling edge.
  task automatic press_key(input logic [3:0] d);
    @(negedge clk); key_valid = 1'b1; key_digit = d;
    @(posedge clk); #1; key_valid = 1'b0;
  endtask

  task automatic strobe_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic strobe_stop();
    @(negedge clk); stop_clr = 1'b1;
    @(posedge clk); #1; stop_clr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", state); end
    n_cmp++; if (load_data !== 12'h000) begin n_bad++; $display("FAIL rst_load_data: got %h want 000", load_data); end
    n_cmp++; if (timer_loadn !== 1'b1) begin n_bad++; $display("FAIL rst_loadn: got %b want 1", timer_loadn); end
    n_cmp++; if (timer_en !== 1'b0) begin n_bad++; $display("FAIL rst_timer_en: got %b want 0", timer_en); end
    n_cmp++; if (beep !== 1'b0) begin n_bad++; $display("FAIL rst_beep: got %b want 0", beep); end
    n_cmp++; if (mag_on !== 1'b0 || lamp_on !== 1'b0) begin n_bad++; $display("FAIL rst_mag_lamp: got %b%b want 00", mag_on, lamp_on); end
    @(negedge clk); clrn = 1'b1;
  endtask

  task automatic test_basic_cook();
    int first = -1;
    int cnt = 0;
    press_key(4'd1);
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL key_to_entry: got %0d want 1", state); end
    press_key(4'd2);
    press_key(4'd3);
    strobe_start();
    n_cmp++; if (timer_loadn !== 1'b0) begin n_bad++; $display("FAIL start_loadn: got %b want 0", timer_loadn); end
    n_cmp++; if (load_data !== 12'h123) begin n_bad++; $display("FAIL start_load_data: got %h want 123", load_data); end
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL start_state: got %0d want 2", state); end
    n_cmp++; if (mag_on !== 1'b1 || lamp_on !== 1'b1) begin n_bad++; $display("FAIL cook_mag_lamp: got %b%b want 11", mag_on, lamp_on); end
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        n_cmp++; if (timer_loadn !== 1'b1) begin n_bad++; $display("FAIL loadn_one_cycle: got %b want 1", timer_loadn); end
      end
      if (timer_en) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    n_cmp++; if (first !== 5) begin n_bad++; $display("FAIL first_tick: got cycle %0d want 5", first); end
    n_cmp++; if (cnt !== 2) begin n_bad++; $display("FAIL tick_count: got %0d want 2", cnt); end
  endtask

  task automatic test_pause();
    int cnt = 0;
    int first = -1;
    @(negedge clk); door_closed = 1'b0;
    #1;
    n_cmp++; if (mag_on !== 1'b0 || lamp_on !== 1'b1) begin n_bad++; $display("FAIL door_cut: got mag %b lamp %b want 0 1", mag_on, lamp_on); end
    @(posedge clk); #1;
    n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL door_pause: got %0d want 3", state); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (timer_en) cnt++;
    end
    n_cmp++; if (cnt !== 0) begin n_bad++; $display("FAIL pause_no_tick: got %0d want 0", cnt); end
    @(negedge clk); door_closed = 1'b1;
    #1;
    n_cmp++; if (lamp_on !== 1'b0) begin n_bad++; $display("FAIL pause_lamp: got %b want 0", lamp_on); end
    strobe_start();
    n_cmp++; if (state !== 3'd2 || timer_loadn !== 1'b1) begin n_bad++; $display("FAIL resume: got state %0d loadn %b want 2 1", state, timer_loadn); end
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      if (timer_en && first < 0) first = i;
    end
    n_cmp++; if (first !== 3) begin n_bad++; $display("FAIL resume_phase: got cycle %0d want 3", first); end
  endtask

  task automatic test_done();
    int beeps = 1;
    int ens = 0;
    @(negedge clk); timer_zero = 1'b1;
    @(posedge clk); #1; timer_zero = 1'b0;
    n_cmp++; if (state !== 3'd4 || beep !== 1'b1) begin n_bad++; $display("FAIL done_enter: got state %0d beep %b want 4 1", state, beep); end
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (beep) beeps++;
      if (timer_en) ens++;
      if (i == 14) begin
        n_cmp++; if (state !== 3'd4) begin n_bad++; $display("FAIL done_hold: got %0d want 4", state); end
      end
      if (i == 15) begin
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL done_exit: got %0d want 0", state); end
      end
    end
    n_cmp++; if (beeps !== 15) begin n_bad++; $display("FAIL beep_len: got %0d want 15", beeps); end
    n_cmp++; if (ens !== 0) begin n_bad++; $display("FAIL done_no_en: got %0d want 0", ens); end
    strobe_start();
    n_cmp++; if (load_data !== 12'h123 || timer_loadn !== 1'b0) begin n_bad++; $display("FAIL entry_kept: got %h loadn %b want 123 0", load_data, timer_loadn); end
  endtask

  task automatic test_done_coincide();
    repeat (4) @(posedge clk);
    @(negedge clk); timer_zero = 1'b1;
    @(posedge clk); #1; timer_zero = 1'b0;
    n_cmp++; if (state !== 3'd4 || timer_en !== 1'b0) begin n_bad++; $display("FAIL coincide: got state %0d en %b want 4 0", state, timer_en); end
    strobe_stop();
    n_cmp++; if (state !== 3'd0 || beep !== 1'b0) begin n_bad++; $display("FAIL done_stop: got state %0d beep %b want 0 0", state, beep); end
  endtask

  task automatic test_settle();
    @(negedge clk); start = 1'b1; timer_zero = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL settle_load: got %0d want 2", state); end
    @(posedge clk); #1;
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL settle_ignore: got %0d want 2", state); end
    @(posedge clk); #1; timer_zero = 1'b0;
    n_cmp++; if (state !== 3'd4) begin n_bad++; $display("FAIL settle_done: got %0d want 4", state); end
    strobe_stop();
  endtask

  task automatic test_clear();
    strobe_start();
    strobe_stop();
    n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL stop_pause: got %0d want 3", state); end
    strobe_stop();
    n_cmp++; if (state !== 3'd0 || timer_loadn !== 1'b0 || load_data !== 12'h000) begin
      n_bad++; $display("FAIL clear_load: got state %0d loadn %b data %h want 0 0 000", state, timer_loadn, load_data);
    end
    strobe_start();
`ifdef QUICK_START_EN
    n_cmp++; if (state !== 3'd2 || load_data !== 12'h030 || timer_loadn !== 1'b0) begin
      n_bad++; $display("FAIL quick_start: got state %0d data %h loadn %b want 2 030 0", state, load_data, timer_loadn);
    end
    strobe_stop();
    strobe_stop();
`else
    n_cmp++; if (state !== 3'd0 || timer_loadn !== 1'b1) begin
      n_bad++; $display("FAIL empty_start: got state %0d loadn %b want 0 1", state, timer_loadn);
    end
`endif
  endtask

  task automatic test_entry();
    press_key(4'd1);
    press_key(4'd2);
    press_key(4'd3);
    press_key(4'd4);
    press_key(4'hC);
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL entry_state: got %0d want 1", state); end
    strobe_start();
    n_cmp++; if (load_data !== 12'h234 || timer_loadn !== 1'b0) begin n_bad++; $display("FAIL shift_entry: got %h loadn %b want 234 0", load_data, timer_loadn); end
    strobe_stop();
    strobe_stop();
  endtask

  task automatic test_priority();
    press_key(4'd5);
    @(negedge clk); start = 1'b1; stop_clr = 1'b1;
    @(posedge clk); #1; start = 1'b0; stop_clr = 1'b0;
    n_cmp++; if (state !== 3'd0 || timer_loadn !== 1'b1) begin n_bad++; $display("FAIL stop_wins: got state %0d loadn %b want 0 1", state, timer_loadn); end
    press_key(4'd7);
    @(negedge clk); door_closed = 1'b0;
    strobe_start();
    n_cmp++; if (state !== 3'd1 || timer_loadn !== 1'b1) begin n_bad++; $display("FAIL door_open_start: got state %0d loadn %b want 1 1", state, timer_loadn); end
    @(negedge clk); door_closed = 1'b1;
    strobe_stop();
  endtask

  task automatic test_reset_mid_cook();
    press_key(4'd9);
    strobe_start();
    repeat (3) @(posedge clk);
    #2; clrn = 1'b0;
    #1;
    n_cmp++; if (state !== 3'd0 || load_data !== 12'h000 || timer_loadn !== 1'b1) begin
      n_bad++; $display("FAIL mid_rst_regs: got state %0d data %h loadn %b want 0 000 1", state, load_data, timer_loadn);
    end
    n_cmp++; if (timer_en !== 1'b0 || beep !== 1'b0 || mag_on !== 1'b0 || lamp_on !== 1'b0) begin
      n_bad++; $display("FAIL mid_rst_outs: got en %b beep %b mag %b lamp %b want 0000", timer_en, beep, mag_on, lamp_on);
    end
    @(negedge clk); clrn = 1'b1;
    strobe_start();
`ifdef QUICK_START_EN
    n_cmp++; if (load_data !== 12'h030) begin n_bad++; $display("FAIL rst_entry_quick: got %h want 030", load_data); end
`else
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL rst_entry_cleared: got %0d want 0", state); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_cook();
    test_pause();
    test_done();
    test_done_coincide();
    test_settle();
    test_clear();
    test_entry();
    test_priority();
    test_reset_mid_cook();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
